// File: rtl/one_hot_pkg.sv
// Shared types and helpers for one-hot bus checkers.
// The popcount helper works on a fixed 64-bit argument so callers of any width up to 64 can share it.
package one_hot_pkg;

    typedef enum logic {MON_OK, MON_FAULT} mon_state_t;

    localparam int POP_MAX_W = 64;

    // Clearing the lowest set bit leaves something only if two or more bits were set.
    function automatic logic onehot_popcnt_ge2(input logic [POP_MAX_W-1:0] x);
        return (x & (x - 64'd1)) != '0;
    endfunction

endpackage

// File: rtl/one_hot_encoder.sv
// Combinational classifier for a one-hot bus: zero / multi-hot flags and
// the index of the lowest set bit.
module one_hot_encoder
    import one_hot_pkg::*;
#(
    parameter int INPUT_WIDTH = 16,
    parameter int IDX_WIDTH   = $clog2(INPUT_WIDTH)
) (
    input  logic [INPUT_WIDTH-1:0] val_in,
    output logic                   is_zero,
    output logic                   is_multi,
    output logic [IDX_WIDTH-1:0]   idx
);

    logic [POP_MAX_W-1:0] val_ext;

    assign val_ext  = POP_MAX_W'(val_in);
    assign is_zero  = (val_in == '0);
    assign is_multi = onehot_popcnt_ge2(val_ext);

    // Scan from the top so the lowest set bit has the final word.
    always_comb begin
        idx = '0;
        for (int i = INPUT_WIDTH - 1; i >= 0; i--) begin
            if (val_in[i]) idx = IDX_WIDTH'(i);
        end
    end

endmodule

// File: rtl/one_hot_monitor.sv
// Registered one-hot checker: classifies each en sample, tracks the hot index,
// and keeps a sticky fault with first-error capture and a saturating count.
module one_hot_monitor
    import one_hot_pkg::*;
#(
    parameter int        INPUT_WIDTH = 16,
    parameter bit        ALLOW_ZERO  = 1'b0,
    parameter int        CNT_WIDTH   = 8,
    localparam int       IDX_WIDTH   = $clog2(INPUT_WIDTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic [INPUT_WIDTH-1:0] val_in,
    input  logic                   clr,
    output logic                   out_valid,
    output logic                   is_one_hot,
    output logic [IDX_WIDTH-1:0]   hot_idx,
    output logic                   err,
    output logic [CNT_WIDTH-1:0]   err_cnt,
    output logic [INPUT_WIDTH-1:0] first_err_val
);

    logic                   is_zero, is_multi;
    logic [IDX_WIDTH-1:0]   enc_idx;
    logic                   bad_cls, violation, legal_hot;

    mon_state_t             state_q, state_d;
    logic                   out_valid_q, out_valid_d;
    logic                   is_one_hot_q, is_one_hot_d;
    logic [IDX_WIDTH-1:0]   hot_idx_q, hot_idx_d;
    logic [CNT_WIDTH-1:0]   err_cnt_q, err_cnt_d;
    logic [INPUT_WIDTH-1:0] first_err_val_q, first_err_val_d;

    one_hot_encoder #(
        .INPUT_WIDTH (INPUT_WIDTH),
        .IDX_WIDTH   (IDX_WIDTH)
    ) u_enc (
        .val_in   (val_in),
        .is_zero  (is_zero),
        .is_multi (is_multi),
        .idx      (enc_idx)
    );

    assign bad_cls   = is_multi || (is_zero && !ALLOW_ZERO);
    assign violation = en && bad_cls;
    assign legal_hot = en && !is_multi && !is_zero;

    // A violation in the clr cycle wins: the clear is folded into the capture.
    always_comb begin
        state_d         = state_q;
        out_valid_d     = en;
        is_one_hot_d    = is_one_hot_q;
        hot_idx_d       = hot_idx_q;
        err_cnt_d       = err_cnt_q;
        first_err_val_d = first_err_val_q;

        if (en)        is_one_hot_d = !bad_cls;
        if (legal_hot) hot_idx_d    = enc_idx;

        unique case (state_q)
            MON_OK:    if (violation) state_d = MON_FAULT;
            MON_FAULT: if (clr && !violation) state_d = MON_OK;
            default:   state_d = MON_OK;
        endcase

        if (violation) begin
            if (clr)                  err_cnt_d = CNT_WIDTH'(1);
            else if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
            if (clr || state_q == MON_OK) first_err_val_d = val_in;
        end else if (clr) begin
            err_cnt_d       = '0;
            first_err_val_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= MON_OK;
            out_valid_q     <= 1'b0;
            is_one_hot_q    <= 1'b0;
            hot_idx_q       <= '0;
            err_cnt_q       <= '0;
            first_err_val_q <= '0;
        end else begin
            state_q         <= state_d;
            out_valid_q     <= out_valid_d;
            is_one_hot_q    <= is_one_hot_d;
            hot_idx_q       <= hot_idx_d;
            err_cnt_q       <= err_cnt_d;
            first_err_val_q <= first_err_val_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign is_one_hot    = is_one_hot_q;
    assign hot_idx       = hot_idx_q;
    assign err           = (state_q == MON_FAULT);
    assign err_cnt       = err_cnt_q;
    assign first_err_val = first_err_val_q;

endmodule

// File: tb/tb_one_hot_monitor.sv
// Scoreboard bench for one_hot_monitor: strict-mode DUT plus a zero-allowed DUT.
module tb_one_hot_monitor;

    typedef struct packed {
        logic        ohot;
        logic [3:0]  idx;
        logic        err;
        logic [3:0]  cnt;
        logic [15:0] fev;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en, clr, en_z, clr_z;
    logic [15:0] val_in, val_z;

    logic        out_valid, is_one_hot, err;
    logic [3:0]  hot_idx, err_cnt;
    logic [15:0] first_err_val;
    logic        out_valid_z, is_one_hot_z, err_z;
    logic [3:0]  hot_idx_z, err_cnt_z;
    logic [15:0] first_err_val_z;

    exp_t act_m, act_z;
    exp_t q[$];
    exp_t qz[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    one_hot_monitor #(.INPUT_WIDTH(16), .ALLOW_ZERO(1'b0), .CNT_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .val_in(val_in), .clr(clr),
        .out_valid(out_valid), .is_one_hot(is_one_hot), .hot_idx(hot_idx),
        .err(err), .err_cnt(err_cnt), .first_err_val(first_err_val)
    );

    one_hot_monitor #(.INPUT_WIDTH(16), .ALLOW_ZERO(1'b1), .CNT_WIDTH(4)) dut_z (
        .clk(clk), .rst_n(rst_n), .en(en_z), .val_in(val_z), .clr(clr_z),
        .out_valid(out_valid_z), .is_one_hot(is_one_hot_z), .hot_idx(hot_idx_z),
        .err(err_z), .err_cnt(err_cnt_z), .first_err_val(first_err_val_z)
    );

    assign act_m = {is_one_hot, hot_idx, err, err_cnt, first_err_val};
    assign act_z = {is_one_hot_z, hot_idx_z, err_z, err_cnt_z, first_err_val_z};

    function automatic exp_t mk(logic o, logic [3:0] i, logic e, logic [3:0] c, logic [15:0] f);
        return {o, i, e, c, f};
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic chk_out(input string tag, input exp_t e, input exp_t a);
        chk({tag, ".is_one_hot"},    16'(a.ohot), 16'(e.ohot));
        chk({tag, ".hot_idx"},       16'(a.idx),  16'(e.idx));
        chk({tag, ".err"},           16'(a.err),  16'(e.err));
        chk({tag, ".err_cnt"},       16'(a.cnt),  16'(e.cnt));
        chk({tag, ".first_err_val"}, a.fev,       e.fev);
    endtask

    // Monitors: every out_valid pulse must match the oldest pending expectation.
    always @(negedge clk) begin : mon_main
        exp_t e;
        if (rst_n && out_valid) begin
            if (q.size() == 0) begin
                checks++; errors++;
                $display("FAIL main.unexpected_valid: got out_valid=1, expected 0");
            end else begin
                e = q.pop_front();
                chk_out("main", e, act_m);
            end
        end
    end

    always @(negedge clk) begin : mon_zero
        exp_t e;
        if (rst_n && out_valid_z) begin
            if (qz.size() == 0) begin
                checks++; errors++;
                $display("FAIL zero.unexpected_valid: got out_valid=1, expected 0");
            end else begin
                e = qz.pop_front();
                chk_out("zero", e, act_z);
            end
        end
    end

    task automatic smp(input logic [15:0] v, input logic c, input exp_t e);
        en = 1'b1; val_in = v; clr = c;
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        en = 1'b0; clr = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic clr_only(input string tag, input exp_t e);
        en = 1'b0; clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk_out(tag, e, act_m);
        chk({tag, ".out_valid"}, 16'(out_valid), 16'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

    initial begin
        en = 0; clr = 0; val_in = '0;
        en_z = 0; clr_z = 0; val_z = '0;
        rst_n = 1'b0;
        @(negedge clk);
        chk_out("reset", '0, act_m);
        chk("reset.out_valid", 16'(out_valid), 16'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Legal sweep, back-to-back
        smp(16'h0001, 1'b0, mk(1'b1, 4'd0,  1'b0, 4'd0, 16'h0000));
        smp(16'h0010, 1'b0, mk(1'b1, 4'd4,  1'b0, 4'd0, 16'h0000));
        smp(16'h8000, 1'b0, mk(1'b1, 4'd15, 1'b0, 4'd0, 16'h0000));
        idle(1);

        // Zero is illegal in strict mode
        smp(16'h0000, 1'b0, mk(1'b0, 4'd15, 1'b1, 4'd1, 16'h0000));
        idle(1);
        clr_only("clr_idle1", mk(1'b0, 4'd15, 1'b0, 4'd0, 16'h0000));

        // First-error capture, then a legal sample while faulted
        smp(16'h0003, 1'b0, mk(1'b0, 4'd15, 1'b1, 4'd1, 16'h0003));
        smp(16'h00C0, 1'b0, mk(1'b0, 4'd15, 1'b1, 4'd2, 16'h0003));
        smp(16'hFFFF, 1'b0, mk(1'b0, 4'd15, 1'b1, 4'd3, 16'h0003));
        smp(16'h0020, 1'b0, mk(1'b1, 4'd5,  1'b1, 4'd3, 16'h0003));
        idle(1);
        clr_only("clr_idle2", mk(1'b1, 4'd5, 1'b0, 4'd0, 16'h0000));

        // Saturation: 21 illegal samples, counter pins at 15
        for (int k = 1; k <= 21; k++)
            smp(16'h0011, 1'b0, mk(1'b0, 4'd5, 1'b1, 4'((k > 15) ? 15 : k), 16'h0011));

        // clr colliding with a violation, then clr with a legal sample
        smp(16'h0300, 1'b1, mk(1'b0, 4'd5, 1'b1, 4'd1, 16'h0300));
        smp(16'h0002, 1'b1, mk(1'b1, 4'd1, 1'b0, 4'd0, 16'h0000));
        smp(16'h0101, 1'b0, mk(1'b0, 4'd1, 1'b1, 4'd1, 16'h0101));

        // Async reset between edges, cutting an in-flight sample
        en = 1'b1; val_in = 16'h0F00; clr = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk_out("async_rst", '0, act_m);
        chk("async_rst.out_valid", 16'(out_valid), 16'd0);
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        smp(16'h0400, 1'b0, mk(1'b1, 4'd10, 1'b0, 4'd0, 16'h0000));
        idle(2);

        // Zero-or-one-hot mode
        en_z = 1'b1; val_z = 16'h0040; qz.push_back(mk(1'b1, 4'd6, 1'b0, 4'd0, 16'h0000));
        @(negedge clk);
        val_z = 16'h0000; qz.push_back(mk(1'b1, 4'd6, 1'b0, 4'd0, 16'h0000));
        @(negedge clk);
        val_z = 16'h0005; qz.push_back(mk(1'b0, 4'd6, 1'b1, 4'd1, 16'h0005));
        @(negedge clk);
        en_z = 1'b0;
        repeat (2) @(negedge clk);

        chk("main.pending", 16'(q.size()), 16'd0);
        chk("zero.pending", 16'(qz.size()), 16'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
